// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and constants for the UART program loader
//
// Package uart_pkg:
//   loader_state_t     frame parser states
//   DEFAULT_SYNC_BYTE  frame start marker used when the top is not overridden
//   HDR_LEN            header bytes per frame (SYNC, LEN_HI, LEN_LO)
//   len_exceeds()      true when a frame length does not fit the program memory
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         HDR_LEN           = 3;

  // A length equal to the memory size is legal; one byte more is not.
  function automatic logic len_exceeds(input logic [15:0] len, input int unsigned addr_w);
    return {1'b0, len} > (17'd1 << addr_w);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - receive-byte and memory-write bundle of the loader
//
// Signals:
//   rx_done    one-cycle byte-valid pulse from the UART receiver
//   rx_data    received byte, valid with rx_done
//   mem_we     program memory write strobe
//   mem_addr   program memory write address (ADDR_W bits)
//   mem_wdata  program memory write data
// Modports:
//   slave   the loader: consumes rx_*, drives mem_*
//   master  the environment: drives rx_*, observes mem_*
interface uart_loader_if #(
  parameter int ADDR_W = 12
) ();

  logic              rx_done;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  rx_done, rx_data,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_done, rx_data,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/uart_loader_timeout.sv
// rtl/uart_loader_timeout.sv - inter-byte timeout down-counter for the loader
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       reload the full budget of CYCLES-1
//   en          count down one step per cycle (saturates at zero)
//   expired     count has reached zero
module loader_timeout #(
  parameter int CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int             W    = $clog2(CYCLES + 1);
  localparam logic [W-1:0]   LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  // Counting down from CYCLES-1 reaches zero after the same number of
  // silent cycles as an up-counter reaching CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed program-image loader fed by the UART receiver
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, LEN payload bytes, CHK (8-bit sum of payload).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   enable      arms the loader; only gates SYNC acceptance in IDLE
//   bus         uart_loader_if.slave: rx_done/rx_data in, mem_we/mem_addr/mem_wdata out
//   cpu_hold    high while a frame is in progress
//   load_done   one-cycle pulse after a frame with a matching checksum
//   error       sticky until the next accepted SYNC or reset
//   tx_start, tx_data  payload echo, present only with UART_LOADER_ECHO_EN defined
module uart_loader
  import uart_pkg::*;
#(
  parameter int         ADDR_W         = 12,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  uart_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          error
`ifdef UART_LOADER_ECHO_EN
  ,
  output logic          tx_start,
  output logic [7:0]    tx_data
`endif
);

  loader_state_t     state;
  logic [7:0]        len_hi;
  logic [15:0]       remaining;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        csum;
  logic [15:0]       len_word;
  logic              expired;

  assign len_word = {len_hi, bus.rx_data};

  // Held loaded while idle, so an accepted SYNC starts a fresh budget,
  // and reloaded by every received byte inside a frame.
  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.rx_done || (state == IDLE)),
    .en      (1'b1),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      len_hi        <= '0;
      remaining     <= '0;
      wr_ptr        <= '0;
      csum          <= '0;
      cpu_hold      <= 1'b0;
      load_done     <= 1'b0;
      error         <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef UART_LOADER_ECHO_EN
      tx_start      <= 1'b0;
      tx_data       <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      load_done  <= 1'b0;
`ifdef UART_LOADER_ECHO_EN
      tx_start   <= 1'b0;
`endif
      if (state == IDLE) begin
        if (bus.rx_done && enable && (bus.rx_data == SYNC_BYTE)) begin
          state     <= LEN_HI;
          cpu_hold  <= 1'b1;
          error     <= 1'b0;
          csum      <= '0;
          remaining <= '0;
        end
      end else if (bus.rx_done) begin
        // A byte arriving on the expiry cycle is still taken.
        case (state)
          LEN_HI: begin
            len_hi <= bus.rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            if (len_word == 16'd0) begin
              state <= CHECK;
            end else if (len_exceeds(len_word, ADDR_W)) begin
              error    <= 1'b1;
              state    <= IDLE;
              cpu_hold <= 1'b0;
            end else begin
              remaining    <= len_word;
              wr_ptr       <= '0;
              bus.mem_addr <= '0;
              state        <= DATA;
            end
          end
          DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= bus.rx_data;
            bus.mem_addr  <= wr_ptr;
            wr_ptr        <= wr_ptr + 1'b1;
            csum          <= csum + bus.rx_data;
            remaining     <= remaining - 1'b1;
`ifdef UART_LOADER_ECHO_EN
            tx_start      <= 1'b1;
            tx_data       <= bus.rx_data;
`endif
            if (remaining == 16'd1) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (bus.rx_data == csum) begin
              load_done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end
        endcase
      end else if (expired) begin
        error    <= 1'b1;
        state    <= IDLE;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking scoreboard bench for uart_loader
`timescale 1ns/1ps
module tb_uart_loader;
  import uart_pkg::*;

  localparam int AW = 4;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic cpu_hold, load_done, error;
`ifdef UART_LOADER_ECHO_EN
  logic       tx_start;
  logic [7:0] tx_data;
`endif

  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_W(AW)) bus ();

  uart_loader #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bus       (bus.slave),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .error     (error)
`ifdef UART_LOADER_ECHO_EN
    ,
    .tx_start  (tx_start),
    .tx_data   (tx_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic prev_rx = 1'b0;
  logic [AW+7:0] exp_q[$];
  logic [7:0] pl[$];
  int idx;
  logic [7:0] sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must follow an rx_done and match the queue head.
  always @(negedge clk) begin
    logic [AW+7:0] e;
    if (bus.mem_we) begin
      wr_cnt++;
      check("wr_latency", 32'(prev_rx), 32'd1);
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e[AW+7:8]));
        check("wr_data", 32'(bus.mem_wdata), 32'(e[7:0]));
`ifdef UART_LOADER_ECHO_EN
        check("echo_start", 32'(tx_start), 32'd1);
        check("echo_data", 32'(tx_data), 32'(e[7:0]));
`endif
      end
    end
`ifdef UART_LOADER_ECHO_EN
    else begin
      check("echo_idle", 32'(tx_start), 32'd0);
    end
`endif
    if (load_done) done_cnt++;
    prev_rx = bus.rx_done;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] len);
    logic [7:0] hdr[HDR_LEN];
    hdr = '{DEFAULT_SYNC_BYTE, len[15:8], len[7:0]};
    for (int i = 0; i < HDR_LEN; i++) begin
      send_byte(hdr[i]);
      if (i == 0) check("hold_after_sync", 32'(cpu_hold), 32'd1);
    end
    idx = 0;
    sum = 8'h00;
  endtask

  task automatic send_body(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AW'(idx), pl[idx]});
      sum = sum + pl[idx];
      send_byte(pl[idx]);
      idx++;
    end
  endtask

  task automatic send_chk(input bit bad);
    send_byte(bad ? sum + 8'd1 : sum);
  endtask

  initial begin
    int d0, w0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);

    // Good 4-byte frame.
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    d0 = done_cnt;
    send_header(16'd4);
    send_body(4);
    check("a_hold_data", 32'(cpu_hold), 32'd1);
    send_chk(1'b0);
    idle(3);
    check("a_done", 32'(done_cnt - d0), 32'd1);
    check("a_err", 32'(error), 32'd0);
    check("a_hold_end", 32'(cpu_hold), 32'd0);
    check("a_q", 32'(exp_q.size()), 32'd0);
    check("a_addr_hold", 32'(bus.mem_addr), 32'd3);

    // Same payload, wrong checksum.
    d0 = done_cnt;
    send_header(16'd4);
    send_body(4);
    send_chk(1'b1);
    idle(3);
    check("b_err", 32'(error), 32'd1);
    check("b_done", 32'(done_cnt - d0), 32'd0);
    check("b_q", 32'(exp_q.size()), 32'd0);

    // Empty frame clears the error.
    d0 = done_cnt;
    w0 = wr_cnt;
    send_header(16'd0);
    send_chk(1'b0);
    idle(3);
    check("z_err", 32'(error), 32'd0);
    check("z_done", 32'(done_cnt - d0), 32'd1);
    check("z_writes", 32'(wr_cnt - w0), 32'd0);

    // Full-size frame: exactly 2^AW bytes.
    pl.delete();
    for (int i = 0; i < (1 << AW); i++) pl.push_back(8'($urandom_range(0, 255)));
    d0 = done_cnt;
    send_header(16'(1 << AW));
    send_body(1 << AW);
    send_chk(1'b0);
    idle(3);
    check("full_done", 32'(done_cnt - d0), 32'd1);
    check("full_addr", 32'(bus.mem_addr), 32'((1 << AW) - 1));
    check("full_err", 32'(error), 32'd0);

    // Silence inside a frame.
    pl = '{8'h01, 8'h02, 8'h03};
    send_header(16'd3);
    send_body(2);
    idle(TO + 5);
    check("to_err", 32'(error), 32'd1);
    check("to_hold", 32'(cpu_hold), 32'd0);
    w0 = wr_cnt;
    send_byte(8'h01);
    idle(3);
    check("to_ignored", 32'(wr_cnt - w0), 32'd0);
    check("to_hold_after", 32'(cpu_hold), 32'd0);

    // Length one past the memory size.
    w0 = wr_cnt;
    send_header(16'((1 << AW) + 1));
    idle(1);
    check("big_err", 32'(error), 32'd1);
    check("big_hold", 32'(cpu_hold), 32'd0);
    check("big_writes", 32'(wr_cnt - w0), 32'd0);

    // Disarmed loader ignores SYNC.
    enable = 1'b0;
    w0 = wr_cnt;
    send_byte(8'hA5);
    check("dis_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h55);
    idle(3);
    check("dis_writes", 32'(wr_cnt - w0), 32'd0);
    check("dis_hold_end", 32'(cpu_hold), 32'd0);
    check("dis_err_sticky", 32'(error), 32'd1);

    // Reset in the middle of a frame.
    enable = 1'b1;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_header(16'd4);
    send_body(2);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold", 32'(cpu_hold), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_err", 32'(error), 32'd0);
    idle(2);
    rst_n = 1'b1;
    d0 = done_cnt;
    w0 = wr_cnt;
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'hAA);
    idle(3);
    check("mid_rst_writes", 32'(wr_cnt - w0), 32'd0);
    check("mid_rst_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_hold2", 32'(cpu_hold), 32'd0);

    // Byte arriving exactly on the expiry cycle wins.
    pl = '{8'h10, 8'h20};
    d0 = done_cnt;
    send_header(16'd2);
    send_body(1);
    repeat (TO - 2) @(posedge clk);
    send_body(1);
    send_chk(1'b0);
    idle(3);
    check("edge_err", 32'(error), 32'd0);
    check("edge_done", 32'(done_cnt - d0), 32'd1);
    check("edge_q", 32'(exp_q.size()), 32'd0);

    // One cycle later is too late.
    d0 = done_cnt;
    w0 = wr_cnt;
    send_header(16'd2);
    send_body(1);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h20);
    idle(3);
    check("late_err", 32'(error), 32'd1);
    check("late_writes", 32'(wr_cnt - w0), 32'd1);
    check("late_hold", 32'(cpu_hold), 32'd0);
    check("late_done", 32'(done_cnt - d0), 32'd0);

    idle(5);
    check("final_q", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
